ahb_burst_master_seq: RTL and testbench

Parametrised AHB manager-side burst sequencer. Accepts one burst request per handshake and drives HTRANS/HADDR/HBURST/HSIZE beat by beat, with the address phase of beat n+1 pipelined over the data phase of beat n. Generates addresses for all burst_e types and for undefined-length INCR, splits at 1KB boundaries, and aborts on ERROR responses. Sits between a DMA or bus-bridge front end and the AHB manager port.

---
 rtl/ahb_burst_master_seq_pkg.sv | 56 +++++
 rtl/ahb_burst_addr_next.sv | 30 +++
 rtl/ahb_burst_master_seq.sv | 142 ++++++++++++++
 tb/tb_ahb_burst_master_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_burst_master_seq_pkg.sv
// Shared AHB types and helpers for the burst sequencer and its address
// calculator; also usable by subordinate-side models.
package ahb_burst_master_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } trans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_e;

  typedef enum logic [2:0] {
    BYTE         = 3'd0,
    HALFWORD     = 3'd1,
    WORD         = 3'd2,
    DWORD        = 3'd3,
    LINE_4WORDS  = 3'd4,
    LINE_8WORDS  = 3'd5,
    LINE_16WORDS = 3'd6,
    LINE_32WORDS = 3'd7
  } size_e;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } resp_e;

  localparam int BOUNDARY_1KB = 1024;

  // 0 means undefined-length INCR; the length then comes from the request.
  function automatic logic [4:0] burst_beats(burst_e b);
    case (b)
      SINGLE:        return 5'd1;
      WRAP4, INCR4:  return 5'd4;
      WRAP8, INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:       return 5'd0;
    endcase
  endfunction

  function automatic logic is_wrap(burst_e b);
    return (b == WRAP4) || (b == WRAP8) || (b == WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_next.sv
// Combinational next-beat address for an AHB burst, with a flag for
// incrementing bursts whose next beat starts a new 1KB region.
module ahb_burst_addr_next
  import ahb_burst_master_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  size_e             size,
  input  burst_e            burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              crosses_1kb
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wmask;

  always_comb begin
    step  = ADDR_W'(1) << size;
    incr  = addr + step;
    // wrap window is beats*bytes; only meaningful for WRAPn
    wmask = (ADDR_W'(burst_beats(burst)) << size) - ADDR_W'(1);
    if (is_wrap(burst)) next_addr = (addr & ~wmask) | (incr & wmask);
    else                next_addr = incr;
    crosses_1kb = !is_wrap(burst) &&
                  ((next_addr & ADDR_W'(BOUNDARY_1KB - 1)) == '0);
  end

endmodule

// File: rtl/ahb_burst_master_seq.sv
// AHB manager-side burst sequencer: one request per handshake, address
// phase of beat n+1 overlapped with the data phase of beat n.
module ahb_burst_master_seq
  import ahb_burst_master_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_burst,
  input  logic [2:0]        req_size,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic [2:0]        HBURST,
  output logic [2:0]        HSIZE,
  output logic              beat_ack,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (LEN_W > 5) ? LEN_W : 5;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST, ST_ERR} state_e;

  state_e            state;
  logic [CNT_W-1:0]  cnt;        // address phases still to issue after the current one
  logic              data_pend;  // a data phase is outstanding on the bus
  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_cross;
  logic              size_ok;
  logic [CNT_W-1:0]  req_beats;
  logic [ADDR_W-1:0] req_aligned;
  logic [4:0]        fixed_beats;

  ahb_burst_addr_next #(.ADDR_W(ADDR_W)) u_addr_next (
    .addr        (HADDR),
    .size        (size_e'(HSIZE)),
    .burst       (burst_e'(HBURST)),
    .next_addr   (nxt_addr),
    .crosses_1kb (nxt_cross)
  );

  always_comb begin
    size_ok     = (32'd8 << req_size) <= 32'(DATA_W);
    req_aligned = req_addr & ~((ADDR_W'(1) << req_size) - ADDR_W'(1));
    fixed_beats = burst_beats(burst_e'(req_burst));
    if (fixed_beats != 5'd0)  req_beats = CNT_W'(fixed_beats);
    else if (req_len == '0)   req_beats = CNT_W'(1);
    else                      req_beats = CNT_W'(req_len);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HTRANS    <= IDLE;
      HADDR     <= '0;
      HBURST    <= SINGLE;
      HSIZE     <= BYTE;
      req_ready <= 1'b1;
      beat_ack  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      data_pend <= 1'b0;
    end else begin
      beat_ack <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (!size_ok) begin
              err <= 1'b1;
            end else begin
              HTRANS    <= NONSEQ;
              HADDR     <= req_aligned;
              HBURST    <= req_burst;
              HSIZE     <= req_size;
              cnt       <= req_beats - 1'b1;
              data_pend <= 1'b0;
              req_ready <= 1'b0;
              state     <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // first ERROR cycle: drop the pending address immediately
          if (data_pend && !HREADY && HRESP == ERROR) begin
            HTRANS    <= IDLE;
            data_pend <= 1'b0;
            state     <= ST_ERR;
          end else if (HREADY) begin
            beat_ack  <= data_pend && (HRESP == OKAY);
            data_pend <= 1'b1;
            if (cnt == '0) begin
              HTRANS <= IDLE;
              state  <= ST_LAST;
            end else begin
              cnt   <= cnt - 1'b1;
              HADDR <= nxt_addr;
              if (nxt_cross) begin
                HTRANS <= NONSEQ;
                HBURST <= INCR;
              end else begin
                HTRANS <= SEQ;
              end
            end
          end
        end
        ST_LAST: begin
          if (!HREADY && HRESP == ERROR) begin
            data_pend <= 1'b0;
            state     <= ST_ERR;
          end else if (HREADY) begin
            beat_ack  <= 1'b1;
            done      <= 1'b1;
            data_pend <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (HREADY) begin
            err       <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master_seq.sv
// Directed bench for ahb_burst_master_seq with hand-computed bus sequences.
module tb_ahb_burst_master_seq;
  import ahb_burst_master_seq_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_burst = '0;
  logic [2:0]  req_size = '0;
  logic [7:0]  req_len = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic        beat_ack, done, err;

  ahb_burst_master_seq #(.ADDR_W(32), .DATA_W(64), .LEN_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_burst(req_burst), .req_size(req_size), .req_len(req_len),
    .HREADY(HREADY), .HRESP(HRESP),
    .HTRANS(HTRANS), .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE),
    .beat_ack(beat_ack), .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa [32];
  logic [1:0]  qt [32];
  logic [2:0]  qb [32];
  int na, nack, ndone, nerr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                      input logic [7:0] l);
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_burst = b; req_size = s; req_len = l;
    tick;
    req_valid = 1'b0;
    chk("first_nonseq", HTRANS, NONSEQ);
    chk("busy_ready", req_ready, 0);
  endtask

  // Runs until done/err; records accepted address phases and checks holds.
  task automatic run(input int stall_cyc, input int stall_len, input int budget);
    logic [31:0] pa;
    logic [1:0]  pt;
    logic        hr;
    logic        fin;
    na = 0; nack = 0; ndone = 0; nerr = 0; fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      HREADY = !(c >= stall_cyc && c < stall_cyc + stall_len);
      if (HREADY && HTRANS[1]) begin
        qa[na] = HADDR; qt[na] = HTRANS; qb[na] = HBURST; na++;
      end
      pa = HADDR; pt = HTRANS; hr = HREADY;
      tick;
      if (!hr) begin
        chk("hold_haddr", HADDR, pa);
        chk("hold_htrans", HTRANS, pt);
      end
      nack += int'(beat_ack); ndone += int'(done); nerr += int'(err);
      if (done || err) begin
        fin = 1'b1;
        break;
      end
    end
    HREADY = 1'b1;
    chk("finished", fin, 1);
  endtask

  task automatic chk_beat(input string nm, input int i, input logic [31:0] a,
                          input logic [1:0] t, input logic [2:0] b);
    chk($sformatf("%s_addr%0d", nm, i), qa[i], a);
    chk($sformatf("%s_trans%0d", nm, i), qt[i], t);
    chk($sformatf("%s_burst%0d", nm, i), qb[i], b);
  endtask

  logic [31:0] wrap_exp [8];

  initial begin
    // reset
    #1 HRESETn = 1'b0;
    tick; tick;
    chk("rst_htrans", HTRANS, IDLE);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hburst", HBURST, SINGLE);
    chk("rst_hsize", HSIZE, BYTE);
    chk("rst_ready", req_ready, 1);
    chk("rst_ack", beat_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    HRESETn = 1'b1;
    tick;

    // INCR4 WORD at 0x100
    send(32'h100, INCR4, WORD, 8'd0);
    run(0, 0, 40);
    chk("incr4_n", na, 4);
    for (int i = 0; i < 4; i++)
      chk_beat("incr4", i, 32'h100 + 32'(4 * i), (i == 0) ? NONSEQ : SEQ, INCR4);
    chk("incr4_acks", nack, 4);
    chk("incr4_done", ndone, 1);
    chk("incr4_err", nerr, 0);
    chk("incr4_ready_after", req_ready, 1);
    chk("incr4_idle_after", HTRANS, IDLE);
    tick;

    // WRAP8 HALFWORD at 0x3A
    wrap_exp = '{32'h3A, 32'h3C, 32'h3E, 32'h30, 32'h32, 32'h34, 32'h36, 32'h38};
    send(32'h3A, WRAP8, HALFWORD, 8'd0);
    run(0, 0, 40);
    chk("wrap8_n", na, 8);
    for (int i = 0; i < 8; i++)
      chk_beat("wrap8", i, wrap_exp[i], (i == 0) ? NONSEQ : SEQ, WRAP8);
    chk("wrap8_acks", nack, 8);
    chk("wrap8_done", ndone, 1);
    tick;

    // INCR len=3 WORD across 1KB at 0x3FC
    send(32'h3FC, INCR, WORD, 8'd3);
    run(0, 0, 40);
    chk("incr3_n", na, 3);
    chk_beat("incr3", 0, 32'h3FC, NONSEQ, INCR);
    chk_beat("incr3", 1, 32'h400, NONSEQ, INCR);
    chk_beat("incr3", 2, 32'h404, SEQ, INCR);
    chk("incr3_acks", nack, 3);
    chk("incr3_done", ndone, 1);
    tick;

    // INCR4 crossing 1KB: HBURST switches to INCR from the crossing beat on
    send(32'h7F8, INCR4, WORD, 8'd0);
    run(0, 0, 40);
    chk("x4_n", na, 4);
    chk_beat("x4", 0, 32'h7F8, NONSEQ, INCR4);
    chk_beat("x4", 1, 32'h7FC, SEQ, INCR4);
    chk_beat("x4", 2, 32'h800, NONSEQ, INCR);
    chk_beat("x4", 3, 32'h804, SEQ, INCR);
    chk("x4_done", ndone, 1);
    tick;

    // INCR8 WORD at 0x40, two wait states on beat 3
    send(32'h40, INCR8, WORD, 8'd0);
    run(2, 2, 40);
    chk("stall_n", na, 8);
    for (int i = 0; i < 8; i++)
      chk_beat("stall", i, 32'h40 + 32'(4 * i), (i == 0) ? NONSEQ : SEQ, INCR8);
    chk("stall_acks", nack, 8);
    chk("stall_done", ndone, 1);
    tick;

    // ERROR on beat 2 of INCR16
    send(32'h200, INCR16, WORD, 8'd0);
    tick;
    chk("e_a1", HADDR, 32'h204);
    chk("e_t1", HTRANS, SEQ);
    chk("e_ack1", beat_ack, 0);
    tick;
    chk("e_ack2", beat_ack, 1);
    chk("e_a2", HADDR, 32'h208);
    HRESP = 1'b1; HREADY = 1'b0;
    tick;
    chk("e_cancel", HTRANS, IDLE);
    chk("e_ack3", beat_ack, 0);
    chk("e_err_early", err, 0);
    chk("e_ready_early", req_ready, 0);
    HREADY = 1'b1;
    tick;
    chk("e_err", err, 1);
    chk("e_done", done, 0);
    chk("e_ack4", beat_ack, 0);
    chk("e_ready", req_ready, 1);
    HRESP = 1'b0;
    tick;
    chk("e_err_once", err, 0);
    chk("e_idle", HTRANS, IDLE);

    // illegal size for a 64-bit bus
    req_valid = 1'b1; req_addr = 32'h0; req_burst = INCR4; req_size = LINE_4WORDS;
    tick;
    req_valid = 1'b0;
    chk("bad_err", err, 1);
    chk("bad_idle", HTRANS, IDLE);
    chk("bad_ready", req_ready, 1);
    tick;
    chk("bad_err_once", err, 0);
    chk("bad_idle2", HTRANS, IDLE);

    // SINGLE DWORD (aligned down), then back-to-back SINGLE BYTE
    send(32'h127, SINGLE, DWORD, 8'd0);
    chk("s1_addr", HADDR, 32'h120);
    chk("s1_size", HSIZE, DWORD);
    run(0, 0, 10);
    chk("s1_n", na, 1);
    chk("s1_acks", nack, 1);
    chk("s1_done", ndone, 1);
    send(32'h55, SINGLE, BYTE, 8'd0);
    chk("s2_addr", HADDR, 32'h55);
    run(0, 0, 10);
    chk("s2_done", ndone, 1);
    tick;

    // async reset during beat 5 of INCR8
    send(32'h0, INCR8, WORD, 8'd0);
    tick; tick; tick; tick;
    chk("r_beat5", HADDR, 32'h10);
    HRESETn = 1'b0;
    #1;
    chk("r_htrans", HTRANS, IDLE);
    chk("r_haddr", HADDR, 0);
    chk("r_hburst", HBURST, SINGLE);
    chk("r_hsize", HSIZE, BYTE);
    chk("r_ready", req_ready, 1);
    chk("r_ack", beat_ack, 0);
    tick;
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("r_nodone", done, 0);
      chk("r_noerr", err, 0);
      chk("r_stay_idle", HTRANS, IDLE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
